ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a bounded wait for ram_ack.
// Latency: grant registered one edge after request; requester ack combinational with ram_ack; timeout after TIMEOUT BUSY cycles.
module ram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              not_reset,
    input  logic              req0_avalid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_avalid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req0_ack,
    output logic              req1_ack,
    output logic [DATA_W-1:0] req_rdata,
    output logic              ram_avalid,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              grant_id,
    output logic              busy,
    output logic              err,
    output logic              err_id
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              ram_avalid_q, ram_avalid_d;
    logic              ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              grant_id_q, grant_id_d;
    logic              last_grant_q, last_grant_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              winner;
    logic              done_ack;
    logic              timeout;

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state_q      <= IDLE;
            ram_avalid_q <= 1'b0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ram_avalid_q <= ram_avalid_d;
            ram_wr_q     <= ram_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ram_avalid_d = ram_avalid_q;
        ram_wr_d     = ram_wr_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        done_ack     = 1'b0;
        timeout      = 1'b0;
        // Under contention the requester not served last time wins.
        winner = (req0_avalid && req1_avalid) ? ~last_grant_q : req1_avalid;

        case (state_q)
            IDLE: begin
                if (req0_avalid || req1_avalid) begin
                    state_d      = BUSY;
                    ram_avalid_d = 1'b1;
                    ram_wr_d     = winner ? req1_wr    : req0_wr;
                    ram_addr_d   = winner ? req1_addr  : req0_addr;
                    ram_wdata_d  = winner ? req1_wdata : req0_wdata;
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    cnt_d        = '0;
                end
            end
            BUSY: begin
                // A real ack takes priority over a timeout in the same cycle.
                if (ram_ack) begin
                    done_ack     = 1'b1;
                    state_d      = IDLE;
                    ram_avalid_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    done_ack     = 1'b1;
                    timeout      = 1'b1;
                    state_d      = IDLE;
                    ram_avalid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ack   = done_ack && !grant_id_q;
    assign req1_ack   = done_ack &&  grant_id_q;
    assign req_rdata  = ram_rdata;
    assign ram_avalid = ram_avalid_q;
    assign ram_wr     = ram_wr_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q == BUSY);
    assign err        = timeout;
    assign err_id     = grant_id_q;

endmodule
